i2s_xmitter: RTL and testbench

//  Serialises the EQ core's processed stereo words (data_L_out/data_R_out) onto the DAC's I2S data pin.

---
 rtl/i2s_xmitter_pkg.sv | 23 ++
 rtl/i2s_xmitter_edge_sync.sv | 30 +++
 rtl/i2s_xmitter.sv | 143 ++++++++++++++
 tb/tb_i2s_xmitter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_xmitter_pkg.sv
// Shared types and constants for the I2S slave transmitter.
package i2s_xmitter_pkg;

  localparam int unsigned AUDIO_W = 32;

  typedef enum logic [1:0] {
    XS_UNSYNC = 2'd0,
    XS_WAIT   = 2'd1,
    XS_SHIFT  = 2'd2,
    XS_PAD    = 2'd3
  } xs_state_e;

  // Stereo pair captured together at each left-slot start
  typedef struct packed {
    logic [AUDIO_W-1:0] left;
    logic [AUDIO_W-1:0] right;
  } stereo_pair_t;

  function automatic logic [AUDIO_W-1:0] gate_word(input logic [AUDIO_W-1:0] w, input logic on);
    return on ? w : '0;
  endfunction

endpackage

// File: rtl/i2s_xmitter_edge_sync.sv
// Synchronises an asynchronous codec clock into clk and emits registered level and edge pulses.
module i2s_xmitter_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;

  // level doubles as the previous-sample register, keeping level and pulses aligned
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= SYNC_STAGES'({sync_q, din});
      level  <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~level;
      fall   <= ~sync_q[SYNC_STAGES-1] & level;
    end
  end

endmodule

// File: rtl/i2s_xmitter.sv
// I2S slave transmitter: serialises a stereo pair captured at each left-slot start onto sdata.
// Optional build macro XMIT_MUTE_EN adds audio_on, which zeroes the pair at frame boundaries.
module i2s_xmitter
  import i2s_xmitter_pkg::*;
#(
  parameter int unsigned WORD_BITS   = 32,
  parameter int unsigned SLOT_BITS   = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bclk,
  input  logic        lrclk,
  input  logic [31:0] data_L_in,
  input  logic [31:0] data_R_in,
`ifdef XMIT_MUTE_EN
  input  logic        audio_on,
`endif
  output logic        sdata,
  output logic        frame_tick
);

  localparam int unsigned CNT_W = $clog2(WORD_BITS + 1);

  if (SLOT_BITS < WORD_BITS || WORD_BITS == 0 || WORD_BITS > AUDIO_W) begin : g_bad_cfg
    $error("i2s_xmitter: WORD_BITS must be 1..AUDIO_W and not exceed SLOT_BITS");
  end

  logic b_rise, b_fall, lrclk_s;
  logic bclk_level_unused, lr_rise_unused, lr_fall_unused;

  i2s_xmitter_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (bclk),
    .level   (bclk_level_unused),
    .rise    (b_rise),
    .fall    (b_fall)
  );

  i2s_xmitter_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lrclk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (lrclk),
    .level   (lrclk_s),
    .rise    (lr_rise_unused),
    .fall    (lr_fall_unused)
  );

  xs_state_e          state_q, state_d;
  logic               lr_q, lr_d;
  logic               new_word_q, new_word_d;
  stereo_pair_t       hold_q, hold_d;
  logic [AUDIO_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               sdata_d, frame_tick_d;
  stereo_pair_t       capture;
  logic [AUDIO_W-1:0] load_word;
  logic               lr_change;

  // Pair presented to the hold registers at a left start
  always_comb begin
`ifdef XMIT_MUTE_EN
    capture.left  = gate_word(data_L_in, audio_on);
    capture.right = gate_word(data_R_in, audio_on);
`else
    capture.left  = data_L_in;
    capture.right = data_R_in;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= XS_UNSYNC;
      lr_q       <= 1'b0;
      new_word_q <= 1'b0;
      hold_q     <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      sdata      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      lr_q       <= lr_d;
      new_word_q <= new_word_d;
      hold_q     <= hold_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      sdata      <= sdata_d;
      frame_tick <= frame_tick_d;
    end
  end

  // Next state: slot starts are detected on bclk rise, bits are launched on bclk fall
  always_comb begin
    state_d      = state_q;
    lr_d         = lr_q;
    new_word_d   = new_word_q;
    hold_d       = hold_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    sdata_d      = sdata;
    frame_tick_d = 1'b0;
    load_word    = '0;
    lr_change    = 1'b0;

    if (b_rise) begin
      lr_d      = lrclk_s;
      lr_change = (lr_q != lrclk_s);
      if (state_q == XS_UNSYNC) begin
        state_d    = XS_WAIT;
        new_word_d = 1'b0;
      end else if (lr_change && !lrclk_s) begin
        hold_d       = capture;
        frame_tick_d = 1'b1;
        new_word_d   = 1'b1;
      end else begin
        // Right starts are ignored until the first left start
        new_word_d = lr_change && (state_q != XS_WAIT);
      end
    end else if (b_fall) begin
      if (new_word_q) begin
        load_word  = lr_q ? hold_q.right : hold_q.left;
        sdata_d    = load_word[AUDIO_W-1];
        shreg_d    = AUDIO_W'({load_word, 1'b0});
        bit_cnt_d  = CNT_W'(1);
        new_word_d = 1'b0;
        state_d    = (WORD_BITS == 1) ? XS_PAD : XS_SHIFT;
      end else begin
        case (state_q)
          XS_SHIFT: begin
            sdata_d   = shreg_q[AUDIO_W-1];
            shreg_d   = AUDIO_W'({shreg_q, 1'b0});
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_d == CNT_W'(WORD_BITS)) state_d = XS_PAD;
          end
          default: sdata_d = 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_xmitter.sv
// Directed bench for i2s_xmitter: frame table plus reset, data-change, stall and mute sequences.
module tb_i2s_xmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, bclk, lrclk;
  logic [31:0] data_l, data_r;
  logic        sdata32, sdata24, tick32, tick24;
`ifdef XMIT_MUTE_EN
  logic        audio_on;
`endif

  i2s_xmitter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .data_L_in  (data_l),
    .data_R_in  (data_r),
`ifdef XMIT_MUTE_EN
    .audio_on   (audio_on),
`endif
    .sdata      (sdata32),
    .frame_tick (tick32)
  );

  i2s_xmitter #(.WORD_BITS(24), .SLOT_BITS(32)) dut24 (
    .clk        (clk),
    .reset_n    (reset_n),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .data_L_in  (data_l),
    .data_R_in  (data_r),
`ifdef XMIT_MUTE_EN
    .audio_on   (audio_on),
`endif
    .sdata      (sdata24),
    .frame_tick (tick24)
  );

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    int          len_l;
    int          len_r;
    logic [63:0] exp_l32;
    logic [63:0] exp_r32;
    logic [63:0] exp_l24;
    logic [63:0] exp_r24;
  } vec_t;

  vec_t vecs[6];
  int   st_l[6];
  int   st_r[6];

  logic got32[$];
  logic got24[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   lat_bad = 0;
  int   lat_good = 0;
  int   tick_cnt = 0;
  int   tick_long = 0;
  logic tick_prev = 1'b0;

  always @(posedge clk) begin
    if (tick32) tick_cnt <= tick_cnt + 1;
    if (tick32 && tick_prev) tick_long <= tick_long + 1;
    tick_prev <= tick32;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  // One bclk period of 8 clks; lrclk moves with the falling edge. Samples sdata at period end.
  task automatic bclk_period(input logic lr);
    logic p;
    int   ch;
    p     = sdata32;
    ch    = 0;
    bclk  = 1'b0;
    lrclk = lr;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (ch == 0 && sdata32 !== p) ch = i;
      if (i == 4) bclk = 1'b1;
    end
    if (ch == 4) lat_good++;
    else if (ch != 0) lat_bad++;
    got32.push_back(sdata32);
    got24.push_back(sdata24);
  endtask

  task automatic send_slot(input logic lr, input int n);
    for (int i = 0; i < n; i++) bclk_period(lr);
  endtask

  // Bits launched in periods s+1 .. s+n, MSB-aligned
  function automatic logic [63:0] word_of(input bit sel24, input int s, input int n);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[63-k] = sel24 ? got24[s+1+k] : got32[s+1+k];
    return w;
  endfunction

  function automatic int ones32(input int a, input int b);
    int c;
    c = 0;
    for (int i = a; i <= b; i++) if (got32[i] !== 1'b0) c++;
    return c;
  endfunction

  initial begin
    int t0, sa, sar, sb, r0, sd, sdr, chg;
    logic p;
`ifdef XMIT_MUTE_EN
    int se, ser, sf, sfr, sg, sgr;
    audio_on = 1'b1;
`endif
    reset_n = 1'b0;
    bclk    = 1'b1;
    lrclk   = 1'b1;
    data_l  = '0;
    data_r  = '0;

    vecs[0] = '{32'h8000_0001, 32'h7FFF_FFFE, 32, 32, 64'h8000_0001_0000_0000, 64'h7FFF_FFFE_0000_0000,
                64'h8000_0000_0000_0000, 64'h7FFF_FF00_0000_0000};
    vecs[1] = '{32'h1234_5678, 32'hA5A5_5A5A, 32, 32, 64'h1234_5678_0000_0000, 64'hA5A5_5A5A_0000_0000,
                64'h1234_5600_0000_0000, 64'hA5A5_5A00_0000_0000};
    vecs[2] = '{32'hDEAD_BEEF, 32'h0F0F_F0F0, 20, 32, 64'hDEAD_B000_0000_0000, 64'h0F0F_F0F0_0000_0000,
                64'hDEAD_B000_0000_0000, 64'h0F0F_F000_0000_0000};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 40, 32, 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000,
                64'hFFFF_FF00_0000_0000, 64'h0000_0000_0000_0000};
    vecs[4] = '{32'hAAAA_AAAA, 32'h5555_5555, 32, 32, 64'hAAAA_AAAA_0000_0000, 64'h5555_5555_0000_0000,
                64'hAAAA_AA00_0000_0000, 64'h5555_5500_0000_0000};
    vecs[5] = '{32'h0000_0001, 32'h8765_4321, 32, 20, 64'h0000_0001_0000_0000, 64'h8765_4000_0000_0000,
                64'h0000_0000_0000_0000, 64'h8765_4000_0000_0000};

    repeat (3) @(posedge clk);
    #1;
    check("reset_sdata", 64'(sdata32), 64'd0);
    check("reset_sdata24", 64'(sdata24), 64'd0);
    check("reset_tick", 64'(tick32), 64'd0);
    reset_n = 1'b1;

    // Sync on a right slot: no output, no tick
    send_slot(1'b1, 32);
    check("wait_silent", 64'(ones32(0, got32.size() - 1)), 64'd0);
    check("wait_no_tick", 64'(tick_cnt), 64'd0);
    t0 = tick_cnt;

    for (int i = 0; i < 6; i++) begin
      data_l  = vecs[i].l;
      data_r  = vecs[i].r;
      st_l[i] = got32.size();
      send_slot(1'b0, vecs[i].len_l);
      st_r[i] = got32.size();
      send_slot(1'b1, vecs[i].len_r);
    end
    check("ticks_per_frame", 64'(tick_cnt - t0), 64'd6);

    // EQ output changes mid right slot: pair in flight is unaffected
    data_l = 32'h1234_5678;
    data_r = 32'hCAFE_F00D;
    sa = got32.size();
    send_slot(1'b0, 32);
    sar = got32.size();
    send_slot(1'b1, 10);
    data_l = 32'hFFFF_0000;
    send_slot(1'b1, 22);
    sb = got32.size();
    send_slot(1'b0, 32);
    send_slot(1'b1, 32);

    for (int i = 0; i < 6; i++) begin
      check($sformatf("v%0d_left32", i), word_of(1'b0, st_l[i], vecs[i].len_l), vecs[i].exp_l32);
      check($sformatf("v%0d_right32", i), word_of(1'b0, st_r[i], vecs[i].len_r), vecs[i].exp_r32);
      check($sformatf("v%0d_left24", i), word_of(1'b1, st_l[i], vecs[i].len_l), vecs[i].exp_l24);
      check($sformatf("v%0d_right24", i), word_of(1'b1, st_r[i], vecs[i].len_r), vecs[i].exp_r24);
    end
    check("chg_old_left", word_of(1'b0, sa, 32), 64'h1234_5678_0000_0000);
    check("chg_old_right", word_of(1'b0, sar, 32), 64'hCAFE_F00D_0000_0000);
    check("chg_new_left", word_of(1'b0, sb, 32), 64'hFFFF_0000_0000_0000);

    // Reset for 3 clks mid right slot
    data_l = 32'h0F0F_0F0F;
    data_r = 32'h0;
    send_slot(1'b0, 32);
    send_slot(1'b1, 12);
    r0 = got32.size();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_reset_sdata", 64'(sdata32), 64'd0);
    reset_n = 1'b1;
    send_slot(1'b1, 20);
    data_l = 32'hC3C3_3C3C;
    data_r = 32'h3C3C_C3C3;
    sd = got32.size();
    send_slot(1'b0, 6);

    // bclk stopped high: sdata must hold
    p   = sdata32;
    chg = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (sdata32 !== p) chg++;
    end
    check("bclk_stall_hold", 64'(chg), 64'd0);
    send_slot(1'b0, 26);
    sdr = got32.size();
    send_slot(1'b1, 32);

`ifdef XMIT_MUTE_EN
    data_l = 32'h1111_1111;
    data_r = 32'h2222_2222;
    se = got32.size();
    send_slot(1'b0, 10);
    audio_on = 1'b0;
    send_slot(1'b0, 22);
    ser = got32.size();
    send_slot(1'b1, 32);
    sf = got32.size();
    send_slot(1'b0, 32);
    sfr = got32.size();
    send_slot(1'b1, 16);
    audio_on = 1'b1;
    send_slot(1'b1, 16);
    sg = got32.size();
    send_slot(1'b0, 32);
    sgr = got32.size();
    send_slot(1'b1, 32);
`endif

    send_slot(1'b0, 2);

    check("rst_silent", 64'(ones32(r0, sd)), 64'd0);
    check("rst_first_left", word_of(1'b0, sd, 32), 64'hC3C3_3C3C_0000_0000);
    check("rst_first_right", word_of(1'b0, sdr, 32), 64'h3C3C_C3C3_0000_0000);
`ifdef XMIT_MUTE_EN
    check("mute_cur_left", word_of(1'b0, se, 32), 64'h1111_1111_0000_0000);
    check("mute_cur_right", word_of(1'b0, ser, 32), 64'h2222_2222_0000_0000);
    check("mute_next_left", word_of(1'b0, sf, 32), 64'h0);
    check("mute_next_right", word_of(1'b0, sfr, 32), 64'h0);
    check("unmute_left", word_of(1'b0, sg, 32), 64'h1111_1111_0000_0000);
    check("unmute_right", word_of(1'b0, sgr, 32), 64'h2222_2222_0000_0000);
`endif
    check("latency_bad_edges", 64'(lat_bad), 64'd0);
    check("latency_edges_seen", 64'(lat_good >= 50), 64'd1);
    check("tick_one_clk", 64'(tick_long), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
